// File: rtl/ins_mem_arbiter_if.sv
// Instruction-memory arbiter bus: fetch requester, loader requester and memory port.
// slave = arbiter view, master = surrounding fetch/loader/memory view.
interface ins_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  INS_MEM_ARB_Fetch_Req;
  logic [ADDR_WIDTH-1:0] INS_MEM_ARB_Fetch_Addr;
  logic                  INS_MEM_ARB_Fetch_Ack;
  logic [31:0]           INS_MEM_ARB_Fetch_Data;
  logic                  INS_MEM_ARB_Fetch_Err;
  logic                  INS_MEM_ARB_Load_Req;
  logic                  INS_MEM_ARB_Load_We;
  logic [ADDR_WIDTH-1:0] INS_MEM_ARB_Load_Addr;
  logic [31:0]           INS_MEM_ARB_Load_Wdata;
  logic                  INS_MEM_ARB_Load_Ack;
  logic [31:0]           INS_MEM_ARB_Load_Rdata;
  logic                  INS_MEM_ARB_Load_Err;
  logic                  INS_MEM_ARB_Mem_Re;
  logic                  INS_MEM_ARB_Mem_We;
  logic [ADDR_WIDTH-1:0] INS_MEM_ARB_Mem_Address;
  logic [31:0]           INS_MEM_ARB_Mem_Data_In;
  logic [31:0]           INS_MEM_ARB_Mem_Data_Out;
  logic                  INS_MEM_ARB_Mem_Read_Valid;
  logic                  INS_MEM_ARB_Mem_Write_Ready;
  logic                  INS_MEM_ARB_Busy;

  modport slave (
    input  INS_MEM_ARB_Fetch_Req, INS_MEM_ARB_Fetch_Addr,
    input  INS_MEM_ARB_Load_Req, INS_MEM_ARB_Load_We, INS_MEM_ARB_Load_Addr, INS_MEM_ARB_Load_Wdata,
    input  INS_MEM_ARB_Mem_Data_Out, INS_MEM_ARB_Mem_Read_Valid, INS_MEM_ARB_Mem_Write_Ready,
    output INS_MEM_ARB_Fetch_Ack, INS_MEM_ARB_Fetch_Data, INS_MEM_ARB_Fetch_Err,
    output INS_MEM_ARB_Load_Ack, INS_MEM_ARB_Load_Rdata, INS_MEM_ARB_Load_Err,
    output INS_MEM_ARB_Mem_Re, INS_MEM_ARB_Mem_We, INS_MEM_ARB_Mem_Address, INS_MEM_ARB_Mem_Data_In,
    output INS_MEM_ARB_Busy
  );

  modport master (
    output INS_MEM_ARB_Fetch_Req, INS_MEM_ARB_Fetch_Addr,
    output INS_MEM_ARB_Load_Req, INS_MEM_ARB_Load_We, INS_MEM_ARB_Load_Addr, INS_MEM_ARB_Load_Wdata,
    output INS_MEM_ARB_Mem_Data_Out, INS_MEM_ARB_Mem_Read_Valid, INS_MEM_ARB_Mem_Write_Ready,
    input  INS_MEM_ARB_Fetch_Ack, INS_MEM_ARB_Fetch_Data, INS_MEM_ARB_Fetch_Err,
    input  INS_MEM_ARB_Load_Ack, INS_MEM_ARB_Load_Rdata, INS_MEM_ARB_Load_Err,
    input  INS_MEM_ARB_Mem_Re, INS_MEM_ARB_Mem_We, INS_MEM_ARB_Mem_Address, INS_MEM_ARB_Mem_Data_In,
    input  INS_MEM_ARB_Busy
  );
endinterface

// File: rtl/ins_mem_arbiter.sv
// Round-robin single-owner sequencer for the instruction memory port (IDLE->ISSUE->RESP).
// Define INS_MEM_ARB_FIXED_PRIO_EN to make fetch always win conflicts.
module ins_mem_arbiter #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic             INS_MEM_ARB_Clk,
  input  logic             INS_MEM_ARB_Reset,
  ins_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic {OWN_FETCH, OWN_LOAD} owner_t;

  state_t                state;
  owner_t                owner;
  owner_t                last_owner;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_we;
  logic [31:0]           lat_wdata;
  logic                  err;
  logic                  mem_re;
  logic                  mem_we;
  logic                  fetch_ack;
  logic                  load_ack;
  logic                  busy;

  logic                  grant_fetch;
  logic                  grant_load;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic                  gnt_we;
  logic [31:0]           gnt_wdata;
  logic                  mem_done;

  always_comb begin
`ifdef INS_MEM_ARB_FIXED_PRIO_EN
    grant_fetch = bus.INS_MEM_ARB_Fetch_Req;
`else
    grant_fetch = bus.INS_MEM_ARB_Fetch_Req &&
                  (!bus.INS_MEM_ARB_Load_Req || last_owner == OWN_LOAD);
`endif
    grant_load = bus.INS_MEM_ARB_Load_Req && !grant_fetch;
    gnt_addr   = grant_fetch ? bus.INS_MEM_ARB_Fetch_Addr : bus.INS_MEM_ARB_Load_Addr;
    gnt_we     = grant_load && bus.INS_MEM_ARB_Load_We;
    gnt_wdata  = grant_load ? bus.INS_MEM_ARB_Load_Wdata : '0;
    mem_done   = lat_we ? bus.INS_MEM_ARB_Mem_Write_Ready : bus.INS_MEM_ARB_Mem_Read_Valid;
  end

  always_ff @(posedge INS_MEM_ARB_Clk) begin
    if (INS_MEM_ARB_Reset) begin
      state      <= IDLE;
      owner      <= OWN_FETCH;
      last_owner <= OWN_LOAD;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      err        <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      fetch_ack  <= 1'b0;
      load_ack   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      fetch_ack <= 1'b0;
      load_ack  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_fetch || grant_load) begin
            owner     <= grant_fetch ? OWN_FETCH : OWN_LOAD;
            lat_addr  <= gnt_addr;
            lat_we    <= gnt_we;
            lat_wdata <= gnt_wdata;
            busy      <= 1'b1;
            // Misaligned requests skip the memory and answer with Err next cycle
            if (gnt_addr[1:0] != 2'b00) begin
              err       <= 1'b1;
              state     <= RESP;
              fetch_ack <= grant_fetch;
              load_ack  <= grant_load;
            end else begin
              err    <= 1'b0;
              state  <= ISSUE;
              mem_re <= !gnt_we;
              mem_we <= gnt_we;
            end
          end
        end
        ISSUE: begin
          if (mem_done) begin
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            state     <= RESP;
            fetch_ack <= (owner == OWN_FETCH);
            load_ack  <= (owner == OWN_LOAD);
          end
        end
        RESP: begin
          last_owner <= owner;
          state      <= IDLE;
          busy       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is the memory's registered output, visible only alongside Ack
  assign bus.INS_MEM_ARB_Fetch_Ack   = fetch_ack;
  assign bus.INS_MEM_ARB_Fetch_Err   = fetch_ack && err;
  assign bus.INS_MEM_ARB_Fetch_Data  = (fetch_ack && !err) ? bus.INS_MEM_ARB_Mem_Data_Out : '0;
  assign bus.INS_MEM_ARB_Load_Ack    = load_ack;
  assign bus.INS_MEM_ARB_Load_Err    = load_ack && err;
  assign bus.INS_MEM_ARB_Load_Rdata  = (load_ack && !err && !lat_we) ? bus.INS_MEM_ARB_Mem_Data_Out : '0;
  assign bus.INS_MEM_ARB_Mem_Re      = mem_re;
  assign bus.INS_MEM_ARB_Mem_We      = mem_we;
  assign bus.INS_MEM_ARB_Mem_Address = lat_addr;
  assign bus.INS_MEM_ARB_Mem_Data_In = lat_wdata;
  assign bus.INS_MEM_ARB_Busy        = busy;
endmodule

// File: tb/tb_ins_mem_arbiter.sv
// Self-checking bench for ins_mem_arbiter: directed vector table, corner sequences,
// and randomized traffic against a transaction-level model with a shadow memory.
module tb_ins_mem_arbiter;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rv = 1'b1;
  logic wr = 1'b1;
  logic mem_clr = 1'b1;
  always #5 clk = ~clk;

  ins_mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
  ins_mem_arbiter #(.ADDR_WIDTH(AW)) dut (
    .INS_MEM_ARB_Clk  (clk),
    .INS_MEM_ARB_Reset(rst),
    .bus              (bus)
  );

  // Instruction memory model: registered read data, level-style ready/valid
  logic [31:0] mem [256];
  assign bus.INS_MEM_ARB_Mem_Read_Valid  = rv;
  assign bus.INS_MEM_ARB_Mem_Write_Ready = wr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      if (bus.INS_MEM_ARB_Mem_Re && rv)
        bus.INS_MEM_ARB_Mem_Data_Out <= mem[bus.INS_MEM_ARB_Mem_Address[AW-1:2]];
      if (bus.INS_MEM_ARB_Mem_We && wr)
        mem[bus.INS_MEM_ARB_Mem_Address[AW-1:2]] <= bus.INS_MEM_ARB_Mem_Data_In;
    end
  end

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fr, input logic [AW-1:0] fa, input logic lr, input logic lw,
                       input logic [AW-1:0] la, input logic [31:0] ld);
    bus.INS_MEM_ARB_Fetch_Req  = fr;
    bus.INS_MEM_ARB_Fetch_Addr = fa;
    bus.INS_MEM_ARB_Load_Req   = lr;
    bus.INS_MEM_ARB_Load_We    = lw;
    bus.INS_MEM_ARB_Load_Addr  = la;
    bus.INS_MEM_ARB_Load_Wdata = ld;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ctl"}, {25'd0, bus.INS_MEM_ARB_Fetch_Ack, bus.INS_MEM_ARB_Fetch_Err,
                        bus.INS_MEM_ARB_Load_Ack, bus.INS_MEM_ARB_Load_Err, bus.INS_MEM_ARB_Mem_Re,
                        bus.INS_MEM_ARB_Mem_We, bus.INS_MEM_ARB_Busy}, 32'd0);
    chk({tag, " addr"}, {22'd0, bus.INS_MEM_ARB_Mem_Address}, 32'd0);
    chk({tag, " wdata"}, bus.INS_MEM_ARB_Mem_Data_In, 32'd0);
    chk({tag, " fdata"}, bus.INS_MEM_ARB_Fetch_Data, 32'd0);
    chk({tag, " ldata"}, bus.INS_MEM_ARB_Load_Rdata, 32'd0);
  endtask

  typedef struct {
    logic          is_load;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_data;
    logic          exp_err;
    int unsigned   exp_lat;
  } vec_t;

  vec_t vt[11];

  // random-phase model state
  logic [31:0]   shadow [256];
  logic          f_pend, l_pend, l_we;
  logic [AW-1:0] f_addr, l_addr;
  logic [31:0]   l_wd;
  int unsigned   f_skip, l_skip, f_wait, l_wait;
  int unsigned   inv_err, rr_err, to_err, n_acks;

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 15)) << 2;
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    logic        got, ack_ld, aerr, busy_ok;
    logic [31:0] adata;
    int unsigned lat, re_n, we_n, n;
    logic        exp_own [4];
    logic [31:0] exp_d;
    logic        exp_e;

    vt[0]  = '{1'b1, 1'b1, 10'h004, 32'h00500093, 32'h0,        1'b0, 2};
    vt[1]  = '{1'b0, 1'b0, 10'h004, 32'h0,        32'h00500093, 1'b0, 2};
    vt[2]  = '{1'b1, 1'b1, 10'h010, 32'hDEADBEEF, 32'h0,        1'b0, 2};
    vt[3]  = '{1'b1, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0, 2};
    vt[4]  = '{1'b0, 1'b0, 10'h006, 32'h0,        32'h0,        1'b1, 1};
    vt[5]  = '{1'b1, 1'b1, 10'h013, 32'h12345678, 32'h0,        1'b1, 1};
    vt[6]  = '{1'b1, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0, 2};
    vt[7]  = '{1'b1, 1'b1, 10'h020, 32'h11111111, 32'h0,        1'b0, 2};
    vt[8]  = '{1'b1, 1'b1, 10'h3FC, 32'hCAFEF00D, 32'h0,        1'b0, 2};
    vt[9]  = '{1'b0, 1'b0, 10'h3FC, 32'h0,        32'hCAFEF00D, 1'b0, 2};
    vt[10] = '{1'b0, 1'b0, 10'h000, 32'h0,        32'h0,        1'b0, 2};

    drive(0, '0, 0, 0, '0, '0);
    tick(); tick();
    chk_reset_outputs("reset");
    mem_clr = 1'b0;
    rst = 1'b0;

    // ---- directed single transactions ----
    for (int i = 0; i < 11; i++) begin
      if (vt[i].is_load) drive(0, '0, 1, vt[i].we, vt[i].addr, vt[i].wdata);
      else               drive(1, vt[i].addr, 0, 0, '0, '0);
      got = 0; ack_ld = 0; lat = 0; re_n = 0; we_n = 0; busy_ok = 1; adata = '0; aerr = 0;
      for (int c = 1; c <= 20 && !got; c++) begin
        tick();
        if (bus.INS_MEM_ARB_Mem_Re) re_n++;
        if (bus.INS_MEM_ARB_Mem_We) we_n++;
        if (!bus.INS_MEM_ARB_Busy) busy_ok = 0;
        if (bus.INS_MEM_ARB_Fetch_Ack || bus.INS_MEM_ARB_Load_Ack) begin
          got = 1; lat = c; ack_ld = bus.INS_MEM_ARB_Load_Ack;
          adata = ack_ld ? bus.INS_MEM_ARB_Load_Rdata : bus.INS_MEM_ARB_Fetch_Data;
          aerr  = ack_ld ? bus.INS_MEM_ARB_Load_Err : bus.INS_MEM_ARB_Fetch_Err;
        end
      end
      drive(0, '0, 0, 0, '0, '0);
      chk($sformatf("vec%0d ack", i), got, 1'b1);
      chk($sformatf("vec%0d latency", i), lat, vt[i].exp_lat);
      chk($sformatf("vec%0d owner", i), ack_ld, vt[i].is_load);
      chk($sformatf("vec%0d data", i), adata, vt[i].exp_data);
      chk($sformatf("vec%0d err", i), aerr, vt[i].exp_err);
      chk($sformatf("vec%0d re cycles", i), re_n, (!vt[i].exp_err && !vt[i].we) ? 1 : 0);
      chk($sformatf("vec%0d we cycles", i), we_n, (!vt[i].exp_err && vt[i].we) ? 1 : 0);
      chk($sformatf("vec%0d busy", i), busy_ok, 1'b1);
      tick();
      chk($sformatf("vec%0d idle", i), bus.INS_MEM_ARB_Busy, 1'b0);
    end

    // ---- both requesters held from the cycle after reset ----
    rst = 1'b1; tick(); rst = 1'b0;
    drive(1, 10'h004, 1, 0, 10'h010, '0);
    for (int k = 0; k < 4; k++) begin
`ifdef INS_MEM_ARB_FIXED_PRIO_EN
      exp_own[k] = 1'b0;
`else
      exp_own[k] = k[0];
`endif
    end
    n = 0;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      tick();
      if (bus.INS_MEM_ARB_Fetch_Ack || bus.INS_MEM_ARB_Load_Ack) begin
        chk($sformatf("rr ack%0d owner", n), bus.INS_MEM_ARB_Load_Ack, exp_own[n]);
        chk($sformatf("rr ack%0d cycle", n), c, 2 + 3 * n);
        chk($sformatf("rr ack%0d data", n),
            bus.INS_MEM_ARB_Load_Ack ? bus.INS_MEM_ARB_Load_Rdata : bus.INS_MEM_ARB_Fetch_Data,
            exp_own[n] ? 32'hDEADBEEF : 32'h00500093);
        n++;
      end
    end
    chk("rr ack count", n, 4);
    drive(0, '0, 0, 0, '0, '0);
    tick();

    // ---- read stall: Read_Valid low for the first 4 ISSUE cycles ----
    rv = 1'b0;
    drive(1, 10'h004, 0, 0, '0, '0);
    got = 0; lat = 0; re_n = 0; adata = '0;
    for (int c = 1; c <= 20 && !got; c++) begin
      tick();
      if (bus.INS_MEM_ARB_Mem_Re) re_n++;
      if (c == 5) rv = 1'b1;
      if (bus.INS_MEM_ARB_Fetch_Ack) begin got = 1; lat = c; adata = bus.INS_MEM_ARB_Fetch_Data; end
    end
    rv = 1'b1;
    drive(0, '0, 0, 0, '0, '0);
    chk("stall re cycles", re_n, 5);
    chk("stall ack cycle", lat, 6);
    chk("stall data", adata, 32'h00500093);
    tick();

    // ---- reset during the ISSUE cycle of a stalled write ----
    wr = 1'b0;
    drive(0, '0, 1, 1, 10'h020, 32'h22222222);
    tick();
    chk("midrst we", bus.INS_MEM_ARB_Mem_We, 1'b1);
    chk("midrst addr", {22'd0, bus.INS_MEM_ARB_Mem_Address}, 32'h020);
    chk("midrst wdata", bus.INS_MEM_ARB_Mem_Data_In, 32'h22222222);
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    drive(0, '0, 0, 0, '0, '0);
    rst = 1'b0; wr = 1'b1;
    tick();
    chk("midrst ack dropped", bus.INS_MEM_ARB_Load_Ack, 1'b0);
    chk("midrst mem word", mem[8], 32'h11111111);
    drive(1, 10'h020, 0, 0, '0, '0);
    got = 0; adata = '0;
    for (int c = 1; c <= 20 && !got; c++) begin
      tick();
      if (bus.INS_MEM_ARB_Fetch_Ack) begin got = 1; adata = bus.INS_MEM_ARB_Fetch_Data; end
    end
    drive(0, '0, 0, 0, '0, '0);
    chk("midrst readback", adata, 32'h11111111);
    tick();

    // ---- randomized traffic vs transaction model ----
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    f_pend = 0; l_pend = 0; l_we = 0; f_addr = '0; l_addr = '0; l_wd = '0;
    f_skip = 0; l_skip = 0; f_wait = 0; l_wait = 0;
    inv_err = 0; rr_err = 0; to_err = 0; n_acks = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!f_pend && $urandom_range(0, 2) == 0) begin
        f_pend = 1; f_addr = rand_addr(); f_skip = 0; f_wait = 0;
      end
      if (!l_pend && $urandom_range(0, 2) == 0) begin
        l_pend = 1; l_addr = rand_addr(); l_we = 1'($urandom_range(0, 1)); l_wd = $urandom;
        l_skip = 0; l_wait = 0;
      end
      drive(f_pend, f_addr, l_pend, l_we, l_addr, l_wd);
      rv = ($urandom_range(0, 3) != 0);
      wr = ($urandom_range(0, 3) != 0);
      tick();
      if (bus.INS_MEM_ARB_Mem_Re && bus.INS_MEM_ARB_Mem_We) inv_err++;
      if ((bus.INS_MEM_ARB_Mem_Re || bus.INS_MEM_ARB_Mem_We) && !bus.INS_MEM_ARB_Busy) inv_err++;
      if (bus.INS_MEM_ARB_Fetch_Ack && bus.INS_MEM_ARB_Load_Ack) inv_err++;
      if (!bus.INS_MEM_ARB_Fetch_Ack && (bus.INS_MEM_ARB_Fetch_Err || bus.INS_MEM_ARB_Fetch_Data != 0)) inv_err++;
      if (!bus.INS_MEM_ARB_Load_Ack && (bus.INS_MEM_ARB_Load_Err || bus.INS_MEM_ARB_Load_Rdata != 0)) inv_err++;
      if (bus.INS_MEM_ARB_Fetch_Ack) begin
        n_acks++;
        if (!f_pend) inv_err++;
        exp_e = (f_addr[1:0] != 2'b00);
        exp_d = exp_e ? 32'h0 : shadow[f_addr[AW-1:2]];
        chk("rnd fetch data", bus.INS_MEM_ARB_Fetch_Data, exp_d);
        chk("rnd fetch err", bus.INS_MEM_ARB_Fetch_Err, exp_e);
        f_pend = 0;
        if (l_pend) l_skip++;
`ifndef INS_MEM_ARB_FIXED_PRIO_EN
        if (l_skip > 1) rr_err++;
`endif
      end
      if (bus.INS_MEM_ARB_Load_Ack) begin
        n_acks++;
        if (!l_pend) inv_err++;
        exp_e = (l_addr[1:0] != 2'b00);
        exp_d = (exp_e || l_we) ? 32'h0 : shadow[l_addr[AW-1:2]];
        chk("rnd load data", bus.INS_MEM_ARB_Load_Rdata, exp_d);
        chk("rnd load err", bus.INS_MEM_ARB_Load_Err, exp_e);
        if (!exp_e && l_we) shadow[l_addr[AW-1:2]] = l_wd;
        l_pend = 0;
        if (f_pend) f_skip++;
        if (f_skip > 1) rr_err++;
      end
      if (f_pend) begin f_wait++; if (f_wait == 100) to_err++; end
`ifndef INS_MEM_ARB_FIXED_PRIO_EN
      if (l_pend) begin l_wait++; if (l_wait == 100) to_err++; end
`endif
    end
    chk("rnd invariants", inv_err, 0);
    chk("rnd fairness", rr_err, 0);
    chk("rnd timeouts", to_err, 0);
    chk("rnd enough acks", n_acks > 100, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end
endmodule

// File: doc/ins_mem_arbiter.md
Name: ins_mem_arbiter

Overview:
- Single-owner sequencer for the instruction memory port. Shares it between the core fetch unit (read-only) and the program loader/debug port (read/write).
- Round-robin arbitration. Each granted access runs through a fixed IDLE→ISSUE→RESP sequence, and the requester gets a one-cycle Ack carrying the read data.
- Sits between the fetch stage / loader and the instruction memory. Drives that memory's Re/We/Address/Data_In and consumes its registered Data_Out, Read_Valid and Write_Ready.

Parameters:
ADDR_WIDTH, 10, byte-address width; must match the instruction memory.

Ports:
INS_MEM_ARB_Clk  in  1  single clock; all state updates on the rising edge
INS_MEM_ARB_Reset  in  1  synchronous, active-high reset
INS_MEM_ARB_Fetch_Req  in  1  fetch read request; held until Fetch_Ack
INS_MEM_ARB_Fetch_Addr  in  ADDR_WIDTH  fetch byte address
INS_MEM_ARB_Fetch_Ack  out  1  one-cycle completion pulse
INS_MEM_ARB_Fetch_Data  out  32  read word, valid only with Fetch_Ack
INS_MEM_ARB_Fetch_Err  out  1  misaligned-address flag, valid with Fetch_Ack
INS_MEM_ARB_Load_Req  in  1  loader request; held until Load_Ack
INS_MEM_ARB_Load_We  in  1  1=write, 0=read
INS_MEM_ARB_Load_Addr  in  ADDR_WIDTH  loader byte address
INS_MEM_ARB_Load_Wdata  in  32  loader write word
INS_MEM_ARB_Load_Ack  out  1  one-cycle completion pulse
INS_MEM_ARB_Load_Rdata  out  32  read word, valid with Load_Ack; 0 on writes
INS_MEM_ARB_Load_Err  out  1  misaligned-address flag, valid with Load_Ack
INS_MEM_ARB_Mem_Re  out  1  to memory Re
INS_MEM_ARB_Mem_We  out  1  to memory We
INS_MEM_ARB_Mem_Address  out  ADDR_WIDTH  to memory Address (byte address)
INS_MEM_ARB_Mem_Data_In  out  32  to memory Data_In
INS_MEM_ARB_Mem_Data_Out  in  32  from memory, registered, one-cycle latency
INS_MEM_ARB_Mem_Read_Valid  in  1  from memory
INS_MEM_ARB_Mem_Write_Ready  in  1  from memory
INS_MEM_ARB_Busy  out  1  high whenever state is not IDLE

Behaviour:
- Clocking and reset: one clock domain; reset is synchronous and active-high.
- Reset values:
  - state = IDLE, last_owner = LOAD, so fetch wins the first conflict.
  - All Ack, Err, Mem_Re, Mem_We and Busy outputs = 0.
  - Mem_Address = 0, Mem_Data_In = 0.
  - Fetch_Data = 0, Load_Rdata = 0.
- Reset mid-access: the outstanding access is dropped with no Ack. Any write not yet sampled by the memory is not performed.
- State machine (registers: state, owner, latched addr/we/wdata, err flag):
  - IDLE:
    - No request: stay in IDLE.
    - One request: grant it.
    - Both requesting: grant the one that is not last_owner.
    - On grant: latch owner, address, We and Wdata; go to ISSUE. Later changes to requester inputs are ignored.
    - If latched address[1:0] != 0: set err and go directly to RESP with no memory access.
  - ISSUE:
    - Drive Mem_Re = !we, Mem_We = we, Mem_Address = latched address, Mem_Data_In = latched Wdata.
    - Advance to RESP when Mem_Read_Valid (read) or Mem_Write_Ready (write) is high. Otherwise stay in ISSUE with the drive held (stall).
  - RESP:
    - Assert the owner's Ack for exactly one cycle. Drive Data = Mem_Data_Out for reads, 0 for writes, 0 when err. Drive Err = err.
    - Update last_owner = owner. Go to IDLE.
- Mem_Re and Mem_We are high only in ISSUE. Mem_Address and Mem_Data_In hold their last latched values elsewhere.
- Data and Err outputs are 0 whenever the matching Ack is 0.
- Latency: Req seen in IDLE at cycle 0; ISSUE at cycle 1; Ack and data at cycle 2 (no stall). Throughput: one access per 3 cycles.
- Req still high in the cycle after Ack is a new request. It competes in IDLE under normal round-robin.
- The non-granted requester keeps Req high. It is served at the next IDLE, so the maximum wait is one access.
- Load_We = 1 with Fetch_Req never produces simultaneous memory Re and We. Only one of Mem_Re/Mem_We is ever high.
- Address wrap: the arbiter does no range check. The memory uses address >> 2 modulo its depth.

Optional Feature:
INS_MEM_ARB_FIXED_PRIO_EN:
- Defined: Fetch_Req always wins a conflict and last_owner is ignored. Loader progresses only when fetch is idle; starvation is acceptable in this mode (boot/debug use).
- Undefined: round-robin as described under Behaviour.

Test Plan:
- Reset, then Fetch_Req with Addr 0x004, memory word[1] = 0x00500093 → Mem_Re high cycle 1; Fetch_Ack cycle 2 with Fetch_Data = 0x00500093, Err = 0; Busy high cycles 1–2.
- Load write Addr 0x010, Wdata 0xDEADBEEF; then Load read Addr 0x010 → Mem_We one cycle; Load_Rdata = 0 on write Ack; read Ack returns 0xDEADBEEF.
- Both Req held from the cycle after reset → grants alternate F, L, F, L, with an Ack every 3 cycles. With the macro defined: F, F, F and Load never acked.
- Fetch_Addr 0x006 → Fetch_Ack at cycle 1 with Err = 1 and Data = 0; Mem_Re never asserted.
- Force Mem_Read_Valid low for 4 cycles during ISSUE → Mem_Re held for 5 cycles; Ack follows one cycle after Read_Valid rises.
- Assert Reset in the ISSUE cycle of a write to 0x020 (old value 0x11111111) → no Ack; all outputs at reset values; word at 0x020 still 0x11111111.
